// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB master slice: bus widths, the address
// field that selects a responder, and the transfer FSM state type.
// No ports; imported by apb_addr_decoder and apb_master.

package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Address bits [15:12] pick one of up to 16 responders.
    localparam int SEL_LSB = 12;
    localparam int SEL_MSB = 15;
    localparam int SEL_W   = SEL_MSB - SEL_LSB + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder
// Turns a byte address into a one-hot responder select. The responder
// index is the address field [SEL_MSB:SEL_LSB]. An index beyond the
// populated responders gives an all-zero select and valid=0.
// Ports:
//   addr  in  APB_ADDR_W  byte address from the initiator
//   sel   out NUM_SLAVES  one-hot select (all zero when not valid)
//   valid out 1           index addresses an existing responder

module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = 4
) (
    input  logic [APB_ADDR_W-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  valid
);

    logic [SEL_W-1:0] index;
    logic             unused_addr_bits;

    assign index            = addr[SEL_MSB:SEL_LSB];
    assign unused_addr_bits = ^{addr[APB_ADDR_W-1:SEL_MSB+1], addr[SEL_LSB-1:0]};

    // Compare the index against every populated responder; at most one
    // can match, so the result is one-hot and valid is simply "any match".
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(index) == i) begin
                sel[i] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// apb_master
// Single-transfer APB requester. A transfer strobe in IDLE latches the
// request onto the APB bus, runs SETUP then ACCESS against the decoded
// responder and reports completion with a one-cycle ready pulse.
// Undecodable addresses complete immediately with err=1.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES cycles without PREADY (completes with err=1).
// Ports:
//   PCLK, PRESET          clock, async active-high reset
//   transfer/write        request strobe and direction (1=write)
//   addr/wdata            request address and write data
//   rdata/ready/err       read data, completion pulse, error flag
//   busy                  high while a transfer is in SETUP/ACCESS
//   PADDR/PWDATA/PWRITE   APB address, write data, direction
//   PENABLE/PSEL          APB access phase and one-hot responder select
//   PRDATA/PREADY         per-responder read data and ready

module apb_master
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                  PCLK,
    input  logic                                  PRESET,
    input  logic                                  transfer,
    input  logic                                  write,
    input  logic [APB_ADDR_W-1:0]                 addr,
    input  logic [APB_DATA_W-1:0]                 wdata,
    output logic [APB_DATA_W-1:0]                 rdata,
    output logic                                  ready,
    output logic                                  err,
    output logic                                  busy,
    output logic [APB_ADDR_W-1:0]                 PADDR,
    output logic [APB_DATA_W-1:0]                 PWDATA,
    output logic                                  PWRITE,
    output logic                                  PENABLE,
    output logic [NUM_SLAVES-1:0]                 PSEL,
    input  logic [NUM_SLAVES-1:0][APB_DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]                 PREADY
);

    apb_state_e              state, state_next;
    logic [APB_ADDR_W-1:0]   paddr_d;
    logic [APB_DATA_W-1:0]   pwdata_d, rdata_d;
    logic                    pwrite_d, penable_d, ready_d, err_d;
    logic [NUM_SLAVES-1:0]   psel_d;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_valid;
    logic                    slave_ready;
    logic [APB_DATA_W-1:0]   slave_rdata;
    logic                    timed_out;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decoder (
        .addr  (addr),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    assign busy = (state != IDLE);

    // PSEL stays one-hot for the whole transfer, so masking with it picks
    // exactly the addressed responder's ready and read data.
    always_comb begin
        slave_ready = |(PREADY & PSEL);
        slave_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) begin
                slave_rdata = slave_rdata | PRDATA[i];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_count, wait_count_d;

    assign timed_out = (wait_count == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts ACCESS cycles without PREADY; cleared while in SETUP so every
    // transfer starts its ACCESS phase from zero.
    always_comb begin
        wait_count_d = wait_count;
        if (state == SETUP) begin
            wait_count_d = '0;
        end else if (state == ACCESS && !slave_ready) begin
            wait_count_d = wait_count + TO_W'(1);
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_count <= '0;
        end else begin
            wait_count <= wait_count_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timed_out = 1'b0;
`endif

    // Next-state and next-output logic. Bus registers hold by default and
    // ready/err default low so they can only ever pulse for one cycle.
    always_comb begin
        state_next = state;
        paddr_d    = PADDR;
        pwdata_d   = PWDATA;
        pwrite_d   = PWRITE;
        psel_d     = PSEL;
        penable_d  = PENABLE;
        rdata_d    = rdata;
        ready_d    = 1'b0;
        err_d      = 1'b0;

        case (state)
            IDLE: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwdata_d = wdata;
                    pwrite_d = write;
                    if (dec_valid) begin
                        psel_d     = dec_sel;
                        penable_d  = 1'b0;
                        state_next = SETUP;
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                if (slave_ready) begin
                    if (!PWRITE) begin
                        rdata_d = slave_rdata;
                    end
                    psel_d     = '0;
                    penable_d  = 1'b0;
                    ready_d    = 1'b1;
                    state_next = IDLE;
                end else if (timed_out) begin
                    psel_d     = '0;
                    penable_d  = 1'b0;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                psel_d     = '0;
                penable_d  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // All state and every output register; reset is asynchronous so an
    // in-flight transfer is dropped the moment PRESET rises.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            PADDR   <= paddr_d;
            PWDATA  <= pwdata_d;
            PWRITE  <= pwrite_d;
            PSEL    <= psel_d;
            PENABLE <= penable_d;
            rdata   <= rdata_d;
            ready   <= ready_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master
// Testbench for apb_master (NUM_SLAVES=4, TIMEOUT_CYCLES=16). Responders
// with configurable wait states and a small memory live in the bench.
// A transaction-level model predicts every output cycle by cycle; a
// compare process checks the DUT against it on each falling edge.
// Directed transfers pin the model with hand-computed values.
// Honours APB_MASTER_TIMEOUT_EN for the stuck-responder scenario.

module tb_apb_master;

    localparam int NUM       = 4;
    localparam int TO_CYCLES = 16;
    localparam int NCYC      = 8192;

    logic                     PCLK = 1'b0;
    logic                     PRESET;
    logic                     transfer;
    logic                     write;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     ready;
    logic                     err;
    logic                     busy;
    logic [31:0]              PADDR;
    logic [31:0]              PWDATA;
    logic                     PWRITE;
    logic                     PENABLE;
    logic [NUM-1:0]           PSEL;
    logic [NUM-1:0][31:0]     PRDATA;
    logic [NUM-1:0]           PREADY;

    apb_master #(
        .NUM_SLAVES     (NUM),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .busy     (busy),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Responder side: memory, wait-state config, stuck flag
    logic [31:0] mem [NUM][16];
    bit          mem_loaded = 1'b0;
    int          wait_cfg [NUM];
    bit          stuck [NUM];
    int          acc_cnt [NUM];

    function automatic logic [31:0] initVal(int i, int w);
        return (32'h9E37_79B9 * (i * 16 + w + 1)) ^ 32'h5A5A_0000;
    endfunction

    // Ready appears after wait_cfg ACCESS cycles for the selected responder.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            PRDATA[i] = mem[i][PADDR[5:2]];
            PREADY[i] = PSEL[i] && PENABLE && !stuck[i] && (acc_cnt[i] >= wait_cfg[i]);
        end
    end

    // Responder wait counters and write port; memory is loaded on the first edge.
    always @(posedge PCLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < NUM; i++)
                for (int w = 0; w < 16; w++)
                    mem[i][w] <= initVal(i, w);
            mem_loaded <= 1'b1;
        end
        for (int i = 0; i < NUM; i++) begin
            if (PSEL[i] && PENABLE && !PREADY[i]) acc_cnt[i] <= acc_cnt[i] + 1;
            else acc_cnt[i] <= 0;
            if (PSEL[i] && PENABLE && PREADY[i] && PWRITE)
                mem[i][PADDR[5:2]] <= PWDATA;
        end
    end

    // Reference model: expected outputs per cycle
    logic [31:0]    model_mem [NUM][16];
    int             model_free = 0;
    logic [NUM-1:0] exp_psel    [NCYC];
    bit             exp_penable [NCYC];
    bit             exp_ready   [NCYC];
    bit             exp_err     [NCYC];
    bit             exp_busy    [NCYC];
    bit             exp_pwrite  [NCYC];
    logic [31:0]    exp_paddr   [NCYC];
    logic [31:0]    exp_pwdata  [NCYC];
    logic [31:0]    exp_rdata   [NCYC];

    // Transfer accepted in cycle c: bus values change from c+1; a decoded
    // transfer occupies 1 SETUP + len ACCESS cycles and completes after them.
    function automatic void modelAccept(int c, logic [31:0] a, logic [31:0] d, logic w);
        int idx;
        int len;
        int r;
        bit e;
        bit upd;
        logic [31:0] rv;
        idx = int'(a[15:12]);
        upd = 1'b1;
        rv  = 32'h0;
        for (int k = c + 1; k < NCYC; k++) begin
            exp_paddr[k]  = a;
            exp_pwdata[k] = d;
            exp_pwrite[k] = w;
        end
        if (idx >= NUM) begin
            r = c + 1;
            e = 1'b1;
        end else begin
            if (stuck[idx]) begin
                len = TO_CYCLES;
                e   = 1'b1;
            end else begin
                len = wait_cfg[idx] + 1;
                e   = 1'b0;
            end
            for (int k = c + 1; k <= c + 1 + len && k < NCYC; k++) begin
                exp_psel[k] = NUM'(1) << idx;
                exp_busy[k] = 1'b1;
            end
            for (int k = c + 2; k <= c + 1 + len && k < NCYC; k++)
                exp_penable[k] = 1'b1;
            r = c + 2 + len;
            if (!e) begin
                if (w) begin
                    upd = 1'b0;
                    model_mem[idx][a[5:2]] = d;
                end else begin
                    rv = model_mem[idx][a[5:2]];
                end
            end
        end
        if (r < NCYC) begin
            exp_ready[r] = 1'b1;
            exp_err[r]   = e;
        end
        if (upd)
            for (int k = r; k < NCYC; k++) exp_rdata[k] = rv;
        model_free = r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Compare process: every cycle against the model while enabled.
    always @(negedge PCLK) begin
        if (check_en && cyc < NCYC) begin
            checkOutput("PSEL",    32'(PSEL),    32'(exp_psel[cyc]));
            checkOutput("PENABLE", 32'(PENABLE), 32'(exp_penable[cyc]));
            checkOutput("ready",   32'(ready),   32'(exp_ready[cyc]));
            checkOutput("busy",    32'(busy),    32'(exp_busy[cyc]));
            checkOutput("PADDR",   PADDR,        exp_paddr[cyc]);
            checkOutput("PWDATA",  PWDATA,       exp_pwdata[cyc]);
            checkOutput("PWRITE",  32'(PWRITE),  32'(exp_pwrite[cyc]));
            if (exp_ready[cyc]) begin
                checkOutput("err",   32'(err), 32'(exp_err[cyc]));
                checkOutput("rdata", rdata,    exp_rdata[cyc]);
            end
        end
    end

    // Present a request this cycle; the model takes it only if the master is idle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w);
        transfer = 1'b1;
        addr     = a;
        wdata    = d;
        write    = w;
        if (cyc >= model_free) modelAccept(cyc, a, d, w);
    endtask

    // One request, observed until its ready pulse (bounded).
    task automatic runMeasured(input logic [31:0] a, input logic [31:0] d, input logic w,
                               output int lat, output int pc, output int pe,
                               output logic ev, output logic [31:0] rv, output bit st);
        int n;
        n = cyc; lat = -1; pc = 0; pe = 0; ev = 1'b0; rv = 32'h0; st = 1'b1;
        applyStimulus(a, d, w);
        @(posedge PCLK); #1;
        transfer = 1'b0;
        for (int k = 0; k < 64 && lat < 0; k++) begin
            @(negedge PCLK);
            if (|PSEL) pc++;
            if (PENABLE) pe++;
            if ((|PSEL) && PADDR !== a) st = 1'b0;
            if (ready) begin
                lat = cyc - n;
                ev  = err;
                rv  = rdata;
            end else begin
                @(posedge PCLK);
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout addr 0x%08h: got no ready, expected one within 64 cycles", a);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, pc, pe, lat2, pc2, pe2;
        logic ev, ev2;
        logic [31:0] rv, rv2;
        bit st, st2;
        logic [31:0] a;
        int sidx, bc, rc;

        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        for (int k = 0; k < NCYC; k++) begin
            exp_psel[k] = '0; exp_penable[k] = 0; exp_ready[k] = 0; exp_err[k] = 0;
            exp_busy[k] = 0; exp_pwrite[k] = 0; exp_paddr[k] = '0; exp_pwdata[k] = '0;
            exp_rdata[k] = '0;
        end
        for (int i = 0; i < NUM; i++) begin
            stuck[i] = 1'b0;
            for (int w = 0; w < 16; w++) model_mem[i][w] = initVal(i, w);
        end
        wait_cfg[0] = 0; wait_cfg[1] = 1; wait_cfg[2] = 2; wait_cfg[3] = 0;

        $display("[TB] reset");
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checkOutput("rst_PSEL",    32'(PSEL),    32'h0);
        checkOutput("rst_PENABLE", 32'(PENABLE), 32'h0);
        checkOutput("rst_PWRITE",  32'(PWRITE),  32'h0);
        checkOutput("rst_PADDR",   PADDR,        32'h0);
        checkOutput("rst_PWDATA",  PWDATA,       32'h0);
        checkOutput("rst_rdata",   rdata,        32'h0);
        checkOutput("rst_ready",   32'(ready),   32'h0);
        checkOutput("rst_err",     32'(err),     32'h0);
        checkOutput("rst_busy",    32'(busy),    32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        model_free = cyc;
        check_en = 1'b1;

        $display("[TB] directed transfers");
        runMeasured(32'h0000_1004, 32'h0000_00A5, 1'b1, lat, pc, pe, ev, rv, st);
        checkOutput("wr1_latency", 32'(lat), 32'd4);
        checkOutput("wr1_psel_cycles", 32'(pc), 32'd3);
        checkOutput("wr1_penable_cycles", 32'(pe), 32'd2);
        checkOutput("wr1_err", 32'(ev), 32'd0);
        @(posedge PCLK); #1;
        runMeasured(32'h0000_1004, 32'h0, 1'b0, lat, pc, pe, ev, rv, st);
        checkOutput("rd1_latency", 32'(lat), 32'd4);
        checkOutput("rd1_rdata", rv, 32'h0000_00A5);
        checkOutput("rd1_err", 32'(ev), 32'd0);
        @(posedge PCLK); #1;
        runMeasured(32'h0000_7000, 32'h0, 1'b0, lat, pc, pe, ev, rv, st);
        checkOutput("dec_latency", 32'(lat), 32'd1);
        checkOutput("dec_psel_cycles", 32'(pc), 32'd0);
        checkOutput("dec_err", 32'(ev), 32'd1);
        checkOutput("dec_rdata", rv, 32'h0);
        @(posedge PCLK); #1;
        runMeasured(32'h0000_0008, 32'h1111_2222, 1'b1, lat, pc, pe, ev, rv, st);
        runMeasured(32'h0000_000C, 32'h3333_4444, 1'b1, lat2, pc2, pe2, ev2, rv2, st2);
        checkOutput("b2b_first_latency", 32'(lat), 32'd3);
        checkOutput("b2b_ready_gap", 32'(lat2), 32'd3);
        checkOutput("b2b_paddr_stable1", 32'(st), 32'd1);
        checkOutput("b2b_paddr_stable2", 32'(st2), 32'd1);

`ifdef APB_MASTER_TIMEOUT_EN
        @(posedge PCLK); #1;
        stuck[2] = 1'b1;
        runMeasured(32'h0000_2010, 32'h0, 1'b0, lat, pc, pe, ev, rv, st);
        checkOutput("to_latency", 32'(lat), 32'd18);
        checkOutput("to_penable_cycles", 32'(pe), 32'd16);
        checkOutput("to_err", 32'(ev), 32'd1);
        checkOutput("to_rdata", rv, 32'h0);
        stuck[2] = 1'b0;
`endif

        $display("[TB] random traffic");
        for (int t = 0; t < 600 && cyc < NCYC - 200; t++) begin
            @(posedge PCLK); #1;
            if (cyc >= model_free && $urandom_range(0, 3) == 0)
                for (int i = 0; i < NUM; i++) wait_cfg[i] = $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 45) begin
                a = $urandom;
                sidx = ($urandom_range(0, 5) == 5) ? $urandom_range(4, 15) : $urandom_range(0, 3);
                a[15:12] = sidx[3:0];
                applyStimulus(a, $urandom, 1'($urandom_range(0, 1)));
            end else begin
                transfer = 1'b0;
            end
        end
        @(posedge PCLK); #1;
        transfer = 1'b0;
        for (int k = 0; k < 64 && cyc <= model_free + 1; k++) @(posedge PCLK);
        @(negedge PCLK);
        check_en = 1'b0;

        $display("[TB] stuck responder and reset abort");
        @(posedge PCLK); #1;
        stuck[2] = 1'b1;
        applyStimulus(32'h0000_2020, 32'h0, 1'b0);
        @(posedge PCLK); #1;
        transfer = 1'b0;
`ifndef APB_MASTER_TIMEOUT_EN
        bc = 0; rc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge PCLK);
            if (busy) bc++;
            if (ready) rc++;
        end
        checkOutput("stuck_busy_cycles", 32'(bc), 32'd100);
        checkOutput("stuck_ready_pulses", 32'(rc), 32'd0);
`else
        repeat (2) @(negedge PCLK);
`endif
        @(negedge PCLK);
        checkOutput("pre_reset_penable", 32'(PENABLE), 32'd1);
        #1 PRESET = 1'b1;
        #1;
        checkOutput("abort_PSEL", 32'(PSEL), 32'h0);
        checkOutput("abort_PENABLE", 32'(PENABLE), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        stuck[2] = 1'b0;
        rc = 0; bc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            if (ready) rc++;
            if (busy) bc++;
        end
        checkOutput("abort_ready_pulses", 32'(rc), 32'd0);
        checkOutput("abort_busy_cycles", 32'(bc), 32'd0);
        checkOutput("abort_rdata", rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
